// File: rtl/glb_job_sequencer.sv
// Host-side job sequencer for the accelerator top: streams words into GLB, programs the control
// registers, waits for done, releases GLB and streams an opsum region back out.
module glb_job_sequencer #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned TIMEOUT = 2**20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       job_mapping,
  input  logic [31:0]       job_shape1,
  input  logic [31:0]       job_shape2,
  input  logic              job_bias_sel,
  input  logic [31:0]       job_op_config,
  input  logic [CNT_W-1:0]  job_load_words,
  input  logic [ADDR_W-1:0] job_rd_base,
  input  logic [CNT_W-1:0]  job_rd_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              ctrl_reg_w_en,
  output logic [2:0]        ctrl_reg_wsel,
  output logic [31:0]       ctrl_reg_wdata,
  output logic [3:0]        dram_w_en,
  output logic [ADDR_W-1:0] dram_w_addr,
  output logic [31:0]       dram_w_data,
  output logic [3:0]        dram_r_en,
  output logic [ADDR_W-1:0] dram_r_addr,
  input  logic [31:0]       dram_r_data,
  input  logic              acc_done,
  output logic              busy,
  output logic              job_done,
  output logic              err_timeout
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CFG, S_RUN, S_REL, S_READ
  } state_t;

  state_t              state;
  logic [31:0]         mapping_q, shape1_q, shape2_q, op_config_q;
  logic                bias_sel_q;
  logic [CNT_W-1:0]    load_words_q, rd_words_q;
  logic [ADDR_W-1:0]   rd_base_q;
  logic [CNT_W-1:0]    load_cnt, issued, delivered;
  logic [ADDR_W-1:0]   wr_addr_next, rd_addr_next;
  logic [2:0]          cfg_idx;
  logic [TO_W-1:0]     run_cnt;
  logic [1:0]          inflight, fifo_cnt;
  logic [31:0]         fifo_second;
  logic [RD_LAT-1:0]   rd_pipe;

  logic        pop, push, issue;
  logic [1:0]  cnt_n;
  logic [31:0] head_n, second_n, cfg_wdata;

  // Two-entry output FIFO: out_data is the head slot, fifo_second the tail slot.
  always_comb begin
    pop      = out_valid & out_ready;
    push     = rd_pipe[RD_LAT-1];
    head_n   = out_data;
    second_n = fifo_second;
    cnt_n    = fifo_cnt;
    case ({push, pop})
      2'b10: begin
        if (fifo_cnt == 2'd0) head_n = dram_r_data;
        else                  second_n = dram_r_data;
        cnt_n = 2'(fifo_cnt + 2'd1);
      end
      2'b01: begin
        head_n = fifo_second;
        cnt_n  = 2'(fifo_cnt - 2'd1);
      end
      2'b11: begin
        if (fifo_cnt == 2'd1) head_n = dram_r_data;
        else begin
          head_n   = fifo_second;
          second_n = dram_r_data;
        end
      end
      default: ;
    endcase
    // A word popped this cycle frees its slot in time for a new issue.
    issue = (state == S_READ) && (issued != rd_words_q) &&
            ((3'(fifo_cnt) + 3'(inflight) - 3'(pop)) < 3'd2);
  end

  always_comb begin
    cfg_wdata = op_config_q;
    case (cfg_idx)
      3'd0:    cfg_wdata = mapping_q;
      3'd1:    cfg_wdata = shape1_q;
      3'd2:    cfg_wdata = shape2_q;
      3'd3:    cfg_wdata = {31'd0, bias_sel_q};
      default: cfg_wdata = op_config_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      mapping_q      <= '0;
      shape1_q       <= '0;
      shape2_q       <= '0;
      op_config_q    <= '0;
      bias_sel_q     <= 1'b0;
      load_words_q   <= '0;
      rd_words_q     <= '0;
      rd_base_q      <= '0;
      load_cnt       <= '0;
      issued         <= '0;
      delivered      <= '0;
      wr_addr_next   <= '0;
      rd_addr_next   <= '0;
      cfg_idx        <= '0;
      run_cnt        <= '0;
      inflight       <= '0;
      fifo_cnt       <= '0;
      fifo_second    <= '0;
      rd_pipe        <= '0;
      in_ready       <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      ctrl_reg_w_en  <= 1'b0;
      ctrl_reg_wsel  <= '0;
      ctrl_reg_wdata <= '0;
      dram_w_en      <= '0;
      dram_w_addr    <= '0;
      dram_w_data    <= '0;
      dram_r_en      <= '0;
      dram_r_addr    <= '0;
      busy           <= 1'b0;
      job_done       <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      ctrl_reg_w_en <= 1'b0;
      dram_w_en     <= 4'h0;
      dram_r_en     <= 4'h0;
      job_done      <= 1'b0;
      out_data      <= head_n;
      fifo_second   <= second_n;
      fifo_cnt      <= cnt_n;
      out_valid     <= (cnt_n != 2'd0);
      rd_pipe       <= RD_LAT'({rd_pipe, dram_r_en[0]});
      inflight      <= 2'(inflight + {1'b0, issue} - {1'b0, push});

      case (state)
        S_IDLE: begin
          if (start) begin
            mapping_q    <= job_mapping;
            shape1_q     <= job_shape1;
            shape2_q     <= job_shape2;
            bias_sel_q   <= job_bias_sel;
            op_config_q  <= job_op_config;
            load_words_q <= job_load_words;
            rd_base_q    <= job_rd_base;
            rd_words_q   <= job_rd_words;
            load_cnt     <= '0;
            wr_addr_next <= '0;
            cfg_idx      <= '0;
            busy         <= 1'b1;
            err_timeout  <= 1'b0;
            if (job_load_words != '0) begin
              in_ready <= 1'b1;
              state    <= S_LOAD;
            end else begin
              state    <= S_CFG;
            end
          end
        end

        S_LOAD: begin
          if (in_valid && in_ready) begin
            dram_w_en    <= 4'hF;
            dram_w_addr  <= wr_addr_next;
            dram_w_data  <= in_data;
            wr_addr_next <= ADDR_W'(wr_addr_next + ADDR_W'(4));
            load_cnt     <= CNT_W'(load_cnt + CNT_W'(1));
            if (CNT_W'(load_cnt + CNT_W'(1)) == load_words_q) begin
              in_ready <= 1'b0;
              state    <= S_CFG;
            end
          end
        end

        // op_config goes last so the accelerator starts only on a fully programmed job.
        S_CFG: begin
          ctrl_reg_w_en  <= 1'b1;
          ctrl_reg_wsel  <= cfg_idx;
          ctrl_reg_wdata <= cfg_wdata;
          cfg_idx        <= 3'(cfg_idx + 3'd1);
          if (cfg_idx == 3'd4) begin
            run_cnt <= '0;
            state   <= S_RUN;
          end
        end

        S_RUN: begin
          if (acc_done) begin
            state <= S_REL;
          end else if (run_cnt == TO_W'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= S_REL;
          end else begin
            run_cnt <= TO_W'(run_cnt + TO_W'(1));
          end
        end

        S_REL: begin
          ctrl_reg_w_en  <= 1'b1;
          ctrl_reg_wsel  <= 3'd4;
          ctrl_reg_wdata <= '0;
          issued         <= '0;
          delivered      <= '0;
          rd_addr_next   <= rd_base_q;
          state          <= S_READ;
        end

        S_READ: begin
          if (issue) begin
            dram_r_en    <= 4'hF;
            dram_r_addr  <= rd_addr_next;
            rd_addr_next <= ADDR_W'(rd_addr_next + ADDR_W'(4));
            issued       <= CNT_W'(issued + CNT_W'(1));
          end
          if (pop) delivered <= CNT_W'(delivered + CNT_W'(1));
          if ((rd_words_q == '0) ||
              (pop && (CNT_W'(delivered + CNT_W'(1)) == rd_words_q))) begin
            job_done <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glb_job_sequencer.sv
// Directed bench for glb_job_sequencer with a behavioural GLB (1-cycle read latency)
// and negedge monitors logging writes, control-register writes and readback beats.
module tb_glb_job_sequencer;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned RD_LAT  = 1;
  localparam int unsigned TIMEOUT = 64;

  logic              clk;
  logic              rst;
  logic              start;
  logic [31:0]       job_mapping, job_shape1, job_shape2, job_op_config;
  logic              job_bias_sel;
  logic [CNT_W-1:0]  job_load_words, job_rd_words;
  logic [ADDR_W-1:0] job_rd_base;
  logic              in_valid, in_ready;
  logic [31:0]       in_data;
  logic              out_valid, out_ready;
  logic [31:0]       out_data;
  logic              ctrl_reg_w_en;
  logic [2:0]        ctrl_reg_wsel;
  logic [31:0]       ctrl_reg_wdata;
  logic [3:0]        dram_w_en, dram_r_en;
  logic [ADDR_W-1:0] dram_w_addr, dram_r_addr;
  logic [31:0]       dram_w_data, dram_r_data;
  logic              acc_done, busy, job_done, err_timeout;

  glb_job_sequencer #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .job_mapping(job_mapping), .job_shape1(job_shape1), .job_shape2(job_shape2),
    .job_bias_sel(job_bias_sel), .job_op_config(job_op_config),
    .job_load_words(job_load_words), .job_rd_base(job_rd_base), .job_rd_words(job_rd_words),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ctrl_reg_w_en(ctrl_reg_w_en), .ctrl_reg_wsel(ctrl_reg_wsel), .ctrl_reg_wdata(ctrl_reg_wdata),
    .dram_w_en(dram_w_en), .dram_w_addr(dram_w_addr), .dram_w_data(dram_w_data),
    .dram_r_en(dram_r_en), .dram_r_addr(dram_r_addr), .dram_r_data(dram_r_data),
    .acc_done(acc_done), .busy(busy), .job_done(job_done), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // GLB model: low region is real storage, 0x100 and above return an address-derived pattern.
  logic [31:0] glb [64];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dram_w_en == 4'hF) glb[dram_w_addr[7:2]] <= dram_w_data;
    if (dram_r_en == 4'hF)
      dram_r_data <= (dram_r_addr < 32'h100) ? glb[dram_r_addr[7:2]] : {16'hA5A5, dram_r_addr[15:0]};
    else
      dram_r_data <= 32'hBAD0_BAD0;
  end

  logic [31:0] out_q [$];
  logic [34:0] ctrl_q [$];
  int          ctrl_cyc_q [$];
  logic [31:0] waddr_q [$];
  int wr_cnt = 0, jd_cnt = 0, jd_cycle = 0, err_cycle = 0, overlap_cnt = 0;
  int max_outst = 0, outst = 0, stable_err = 0, rd_issue_cnt = 0;
  logic        prev_stall = 1'b0, prev_err = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      outst      = 0;
      prev_stall = 1'b0;
      prev_err   = 1'b0;
    end else begin
      if (dram_w_en != 4'h0) begin wr_cnt++; waddr_q.push_back(dram_w_addr); end
      if (ctrl_reg_w_en) begin
        ctrl_q.push_back({ctrl_reg_wsel, ctrl_reg_wdata});
        ctrl_cyc_q.push_back(cyc);
      end
      if (ctrl_reg_w_en && dram_w_en != 4'h0) overlap_cnt++;
      if (dram_r_en != 4'h0) begin outst++; rd_issue_cnt++; end
      if (outst > max_outst) max_outst = outst;
      if (prev_stall && (!out_valid || out_data !== prev_data)) stable_err++;
      if (out_valid && out_ready) begin out_q.push_back(out_data); outst--; end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (job_done) begin jd_cnt++; jd_cycle = cyc; end
      if (err_timeout && !prev_err) err_cycle = cyc;
      prev_err = err_timeout;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] mp, input logic [31:0] s1, input logic [31:0] s2,
                        input logic bs, input logic [31:0] opc, input int lw,
                        input logic [31:0] base, input int rw);
    job_mapping    = mp;
    job_shape1     = s1;
    job_shape2     = s2;
    job_bias_sel   = bs;
    job_op_config  = opc;
    job_load_words = CNT_W'(lw);
    job_rd_base    = base;
    job_rd_words   = CNT_W'(rw);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic feed(input int n, input logic [31:0] v0, input bit gaps);
    int guard;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(1) == 0) begin
        in_valid = 1'b0;
        tick(1);
      end
      in_valid = 1'b1;
      in_data  = v0 + 32'(i);
      guard = 0;
      while (!in_ready && guard < 100) begin tick(1); guard++; end
      if (guard >= 100) begin
        total++; bad++;
        $display("FAIL feed_ready_timeout: word %0d never accepted", i);
      end
      tick(1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int jd_base, input int budget, input bit toggle, input string tag);
    int n = 0;
    while (jd_cnt == jd_base && n < budget) begin
      if (toggle) out_ready = ~out_ready;
      tick(1);
      n++;
    end
    if (jd_cnt == jd_base) begin
      total++; bad++;
      $display("FAIL %s_done_timeout: job_done not seen within %0d cycles", tag, budget);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (in_ready !== 1'b0)    begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (ctrl_reg_w_en !== 1'b0) begin bad++; $display("FAIL rst_ctrl_w_en: got %b want 0", ctrl_reg_w_en); end
    total++; if ({dram_w_en, dram_r_en} !== 8'h00) begin bad++; $display("FAIL rst_dram_en: got %h want 00", {dram_w_en, dram_r_en}); end
    total++; if ({job_done, err_timeout} !== 2'b00) begin bad++; $display("FAIL rst_done_err: got %b want 00", {job_done, err_timeout}); end
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_full_job;
    int cb = ctrl_q.size(), ob = out_q.size(), jb = jd_cnt, wb = wr_cnt, n = 0, done_cyc;
    logic [34:0] exp_ctrl [6];
    logic [34:0] got_c;
    logic [31:0] got_o;
    exp_ctrl[0] = {3'd0, 32'h0000_00A1};
    exp_ctrl[1] = {3'd1, 32'h0000_00B2};
    exp_ctrl[2] = {3'd2, 32'h0000_00C3};
    exp_ctrl[3] = {3'd3, 32'h0000_0001};
    exp_ctrl[4] = {3'd4, 32'h0000_0009};
    exp_ctrl[5] = {3'd4, 32'h0000_0000};
    out_ready = 1'b1;
    acc_done  = 1'b0;
    launch(32'hA1, 32'hB2, 32'hC3, 1'b1, 32'h9, 8, 32'h100, 4);
    feed(8, 32'h11, 1'b0);
    while (ctrl_q.size() < cb + 5 && n < 200) begin tick(1); n++; end
    tick(50);
    acc_done = 1'b1;
    done_cyc = cyc;
    n = 0;
    while (ctrl_q.size() < cb + 6 && n < 50) begin tick(1); n++; end
    acc_done = 1'b0;
    wait_done(jb, 200, 1'b0, "full");
    tick(5);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (glb[i] !== 32'h11 + 32'(i)) begin bad++; $display("FAIL full_glb[%0d]: got %h want %h", i, glb[i], 32'h11 + 32'(i)); end
    end
    for (int i = 0; i < 6; i++) begin
      got_c = (cb + i < ctrl_q.size()) ? ctrl_q[cb + i] : 'x;
      total++;
      if (got_c !== exp_ctrl[i]) begin bad++; $display("FAIL full_ctrl[%0d]: got %h want %h", i, got_c, exp_ctrl[i]); end
    end
    total++;
    if (!(cb + 5 < ctrl_cyc_q.size() && ctrl_cyc_q[cb + 5] > done_cyc)) begin
      bad++; $display("FAIL full_release_after_done: release not after done cycle %0d", done_cyc);
    end
    total++; if (out_q.size() - ob !== 4) begin bad++; $display("FAIL full_out_count: got %0d want 4", out_q.size() - ob); end
    for (int i = 0; i < 4; i++) begin
      got_o = (ob + i < out_q.size()) ? out_q[ob + i] : 'x;
      total++;
      if (got_o !== {16'hA5A5, 16'h0100 + 16'(4 * i)}) begin bad++; $display("FAIL full_out[%0d]: got %h want %h", i, got_o, {16'hA5A5, 16'h0100 + 16'(4 * i)}); end
    end
    total++; if (jd_cnt - jb !== 1) begin bad++; $display("FAIL full_job_done_pulses: got %0d want 1", jd_cnt - jb); end
    total++; if (wr_cnt - wb !== 8) begin bad++; $display("FAIL full_write_count: got %0d want 8", wr_cnt - wb); end
    total++; if (overlap_cnt !== 0) begin bad++; $display("FAIL full_w_overlap: got %0d want 0", overlap_cnt); end
    total++; if ({busy, err_timeout} !== 2'b00) begin bad++; $display("FAIL full_idle_flags: got %b want 00", {busy, err_timeout}); end
  endtask

  task automatic test_backpressure;
    int ob = out_q.size(), jb = jd_cnt;
    logic [31:0] got_o;
    out_ready = 1'b0;
    acc_done  = 1'b1;
    launch(32'h1, 32'h2, 32'h3, 1'b0, 32'h5, 0, 32'h200, 16);
    wait_done(jb, 400, 1'b1, "bp");
    out_ready = 1'b1;
    acc_done  = 1'b0;
    tick(3);
    total++; if (out_q.size() - ob !== 16) begin bad++; $display("FAIL bp_out_count: got %0d want 16", out_q.size() - ob); end
    for (int i = 0; i < 16; i++) begin
      got_o = (ob + i < out_q.size()) ? out_q[ob + i] : 'x;
      total++;
      if (got_o !== {16'hA5A5, 16'h0200 + 16'(4 * i)}) begin bad++; $display("FAIL bp_out[%0d]: got %h want %h", i, got_o, {16'hA5A5, 16'h0200 + 16'(4 * i)}); end
    end
    total++; if (max_outst > 2) begin bad++; $display("FAIL bp_outstanding: got %0d want <=2", max_outst); end
    total++; if (stable_err !== 0) begin bad++; $display("FAIL bp_stall_stable: got %0d changes want 0", stable_err); end
  endtask

  task automatic test_in_gaps;
    int wb = wr_cnt, jb = jd_cnt;
    logic [31:0] got_a;
    acc_done = 1'b1;
    launch(32'h1, 32'h2, 32'h3, 1'b0, 32'h7, 10, 32'h0, 0);
    feed(10, 32'h40, 1'b1);
    wait_done(jb, 200, 1'b0, "gaps");
    acc_done = 1'b0;
    tick(2);
    total++; if (wr_cnt - wb !== 10) begin bad++; $display("FAIL gaps_write_count: got %0d want 10", wr_cnt - wb); end
    for (int i = 0; i < 10; i++) begin
      got_a = (wb + i < waddr_q.size()) ? waddr_q[wb + i] : 'x;
      total++;
      if (got_a !== 32'(4 * i)) begin bad++; $display("FAIL gaps_addr[%0d]: got %h want %h", i, got_a, 32'(4 * i)); end
    end
    total++; if (glb[9] !== 32'h49) begin bad++; $display("FAIL gaps_last_word: got %h want 00000049", glb[9]); end
  endtask

  task automatic test_timeout;
    int cb = ctrl_q.size(), ob = out_q.size(), jb = jd_cnt, run_start;
    logic [34:0] got_c;
    acc_done  = 1'b0;
    out_ready = 1'b1;
    launch(32'h1, 32'h2, 32'h3, 1'b0, 32'h3, 0, 32'h300, 2);
    wait_done(jb, 400, 1'b0, "tmo");
    tick(2);
    run_start = (cb + 4 < ctrl_cyc_q.size()) ? ctrl_cyc_q[cb + 4] : -1000;
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL tmo_err_sticky: got %b want 1", err_timeout); end
    total++; if (err_cycle - run_start !== 64) begin bad++; $display("FAIL tmo_err_cycle: got %0d want 64", err_cycle - run_start); end
    got_c = (cb + 5 < ctrl_q.size()) ? ctrl_q[cb + 5] : 'x;
    total++; if (got_c !== {3'd4, 32'h0}) begin bad++; $display("FAIL tmo_release: got %h want %h", got_c, {3'd4, 32'h0}); end
    total++; if (out_q.size() - ob !== 2) begin bad++; $display("FAIL tmo_out_count: got %0d want 2", out_q.size() - ob); end
    got_c = (ob + 1 < out_q.size()) ? 35'(out_q[ob + 1]) : 'x;
    total++; if (got_c !== 35'h0_A5A5_0304) begin bad++; $display("FAIL tmo_out_last: got %h want a5a50304", got_c); end
  endtask

  task automatic test_zero_counts;
    int cb = ctrl_q.size(), jb = jd_cnt, wb = wr_cnt, rb = rd_issue_cnt, rel_cyc;
    logic [34:0] got_c;
    acc_done = 1'b1;
    launch(32'h1, 32'h2, 32'h3, 1'b0, 32'h5, 0, 32'h0, 0);
    total++; if ({busy, err_timeout} !== 2'b10) begin bad++; $display("FAIL zero_accept_flags: got %b want 10", {busy, err_timeout}); end
    tick(2);
    job_op_config = 32'h77;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(jb, 100, 1'b0, "zero");
    tick(10);
    acc_done = 1'b0;
    rel_cyc = (cb + 5 < ctrl_cyc_q.size()) ? ctrl_cyc_q[cb + 5] : -1000;
    total++; if (ctrl_q.size() - cb !== 6) begin bad++; $display("FAIL zero_ctrl_count: got %0d want 6", ctrl_q.size() - cb); end
    got_c = (cb + 4 < ctrl_q.size()) ? ctrl_q[cb + 4] : 'x;
    total++; if (got_c !== {3'd4, 32'h5}) begin bad++; $display("FAIL zero_opcfg: got %h want %h", got_c, {3'd4, 32'h5}); end
    total++; if (jd_cycle - rel_cyc !== 1) begin bad++; $display("FAIL zero_done_after_rel: got %0d want 1", jd_cycle - rel_cyc); end
    total++; if (jd_cnt - jb !== 1) begin bad++; $display("FAIL zero_done_pulses: got %0d want 1", jd_cnt - jb); end
    total++; if ((wr_cnt - wb) + (rd_issue_cnt - rb) !== 0) begin bad++; $display("FAIL zero_no_mem_access: got %0d want 0", (wr_cnt - wb) + (rd_issue_cnt - rb)); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_read;
    int rb = rd_issue_cnt, n = 0, ob, jb;
    logic [176:0] outs;
    logic [31:0]  got_o;
    acc_done  = 1'b1;
    out_ready = 1'b0;
    launch(32'h1, 32'h2, 32'h3, 1'b0, 32'h5, 0, 32'h100, 8);
    while (rd_issue_cnt < rb + 2 && n < 100) begin @(negedge clk); #1; n++; end
    total++; if (rd_issue_cnt - rb !== 2) begin bad++; $display("FAIL mid_two_reads: got %0d want 2", rd_issue_cnt - rb); end
    rst = 1'b1;
    @(negedge clk);
    outs = {in_ready, out_valid, out_data, ctrl_reg_w_en, ctrl_reg_wsel, ctrl_reg_wdata,
            dram_w_en, dram_w_addr, dram_w_data, dram_r_en, dram_r_addr, busy, job_done, err_timeout};
    total++; if (outs !== '0) begin bad++; $display("FAIL mid_rst_outputs: got %h want 0", outs); end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    tick(3);
    ob = out_q.size();
    jb = jd_cnt;
    launch(32'h1, 32'h2, 32'h3, 1'b0, 32'h5, 2, 32'h0, 2);
    feed(2, 32'hAA, 1'b0);
    wait_done(jb, 200, 1'b0, "mid");
    acc_done = 1'b0;
    tick(3);
    total++; if (out_q.size() - ob !== 2) begin bad++; $display("FAIL mid_new_count: got %0d want 2", out_q.size() - ob); end
    for (int i = 0; i < 2; i++) begin
      got_o = (ob + i < out_q.size()) ? out_q[ob + i] : 'x;
      total++;
      if (got_o !== 32'hAA + 32'(i)) begin bad++; $display("FAIL mid_new_out[%0d]: got %h want %h", i, got_o, 32'hAA + 32'(i)); end
    end
    total++; if (jd_cnt - jb !== 1) begin bad++; $display("FAIL mid_new_done: got %0d want 1", jd_cnt - jb); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    job_mapping = '0; job_shape1 = '0; job_shape2 = '0; job_bias_sel = 1'b0;
    job_op_config = '0; job_load_words = '0; job_rd_base = '0; job_rd_words = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; acc_done = 1'b0;
    test_reset;
    test_full_job;
    test_backpressure;
    test_in_gaps;
    test_timeout;
    test_zero_counts;
    test_reset_mid_read;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
